// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the 16x1024 RAM initiator: state encoding, default
// widths and the saturation value of the optional performance counters.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 4;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WRITE = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_WDONE = 3'd4;

  localparam logic [15:0] PERF_SAT = 16'hFFFF;

endpackage

// File: rtl/mem_burst_cnt.sv
// Burst address/beat counter: loadable RAM address that wraps modulo 2^ADDR_W
// plus a down-counting beat counter whose zero value flags the last beat.
module mem_burst_cnt #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = load_addr;
      cnt_d  = load_len;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(1);
      // Hold at zero so the final step of a read burst leaves the counter clean.
      if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_ctrl_16x1024.sv
// CPU-side load/store burst initiator for the 16x1024 single-port RAM.
// Optional perf counters are enabled by defining MEM_CTRL_PERF_CNT_EN.
module mem_ctrl_16x1024
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef MEM_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]       perf_rd_cnt,
  output logic [15:0]       perf_wr_cnt
`endif
);

  state_t state_q, state_d;
  logic   rd_vld_p1_q, rd_vld_p1_d;
  logic   cnt_load, cnt_step, cnt_last;

  mem_burst_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .load_addr (req_addr),
    .load_len  (req_len),
    .step      (cnt_step),
    .addr      (ram_addr),
    .last      (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_vld_p1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_vld_p1_q <= rd_vld_p1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = req_write ? ST_WRITE : ST_READ;
      ST_WRITE: if (wr_valid && cnt_last) state_d = ST_WDONE;
      ST_READ:  if (cnt_last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      ST_WDONE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    wr_ready     = 1'b0;
    ram_write_en = 1'b0;
    ram_read_en  = 1'b0;
    ram_din      = '0;
    done         = 1'b0;
    cnt_load     = 1'b0;
    cnt_step     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        cnt_load  = req_valid;
      end
      ST_WRITE: begin
        wr_ready     = 1'b1;
        ram_write_en = wr_valid;
        ram_din      = wr_data;
        cnt_step     = wr_valid;
      end
      ST_READ: begin
        ram_read_en = 1'b1;
        cnt_step    = 1'b1;
      end
      // DRAIN covers the RAM's registered read: last beat and done coincide.
      ST_DRAIN: done = 1'b1;
      ST_WDONE: done = 1'b1;
      default: ;
    endcase
  end

  // p1: read data returns one cycle after the read enable
  assign rd_vld_p1_d = ram_read_en;
  assign rd_valid    = rd_vld_p1_q;
  assign rd_data     = ram_dout;

`ifdef MEM_CTRL_PERF_CNT_EN
  logic [15:0] perf_rd_q, perf_rd_d;
  logic [15:0] perf_wr_q, perf_wr_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != PERF_SAT)) return v + 16'd1;
    return v;
  endfunction

  always_comb begin
    perf_rd_d = sat_inc(perf_rd_q, ram_read_en);
    perf_wr_d = sat_inc(perf_wr_q, ram_write_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_q <= '0;
      perf_wr_q <= '0;
    end else begin
      perf_rd_q <= perf_rd_d;
      perf_wr_q <= perf_wr_d;
    end
  end

  assign perf_rd_cnt = perf_rd_q;
  assign perf_wr_cnt = perf_wr_q;
`endif

endmodule

// File: tb/tb_mem_ctrl_16x1024.sv
// Scoreboard bench for mem_ctrl_16x1024 with a behavioural RAM and reference memory.
module tb_mem_ctrl_16x1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic        req_ready;
  logic [9:0]  req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid, done, ram_read_en, ram_write_en;
  logic [15:0] rd_data, ram_din;
  logic [15:0] ram_dout = '0;
  logic [9:0]  ram_addr;
`ifdef MEM_CTRL_PERF_CNT_EN
  logic [15:0] perf_rd_cnt, perf_wr_cnt;
`endif

  always #5 clk = ~clk;

  mem_ctrl_16x1024 dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
    .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef MEM_CTRL_PERF_CNT_EN
    , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt)
`endif
  );

  // Behavioural single-port RAM with one-cycle registered read.
  logic [15:0] ram_arr [0:1023];
  always @(posedge clk) begin
    if (ram_write_en) ram_arr[ram_addr] <= ram_din;
    if (ram_read_en)  ram_dout <= ram_arr[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [9:0] a; logic [15:0] d; } wr_t;
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [9:0]  exp_ra[$];
  logic [15:0] wq[$];
  logic [15:0] ref_mem [0:1023];

  int checks = 0, errors = 0;
  int done_exp = 0, done_seen = 0;
  int cur_acc = 0, cur_len = 0, cur_id = 0;
  bit cur_wr = 1'b0;
  int last_wr_cyc = 0, mon_id = -1, mon_beat = 0;
  int pm_rd = 0, pm_wr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: value %0h (t=%0t)", nm, act, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents activity.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cur_id != mon_id) begin
        mon_id   = cur_id;
        mon_beat = 0;
      end
      chk("en_exclusive", {31'b0, ram_read_en & ram_write_en}, 32'd0);
      if (ram_write_en) begin
        if (exp_wr.size() == 0) fail_now("wr_unexpected", {22'b0, ram_addr});
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", {22'b0, ram_addr}, {22'b0, w.a});
          chk("wr_data", {16'b0, ram_din}, {16'b0, w.d});
        end
      end
      if (ram_read_en) begin
        if (exp_ra.size() == 0) fail_now("ra_unexpected", {22'b0, ram_addr});
        else chk("rd_addr", {22'b0, ram_addr}, {22'b0, exp_ra.pop_front()});
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) fail_now("rd_unexpected", {16'b0, rd_data});
        else begin
          chk("rd_data", {16'b0, rd_data}, {16'b0, exp_rd.pop_front()});
          chk("rd_cycle", cyc - cur_acc + 1, mon_beat + 2);
          mon_beat++;
        end
      end
      if (done) begin
        done_seen++;
        if (cur_wr) begin
          chk("wdone_rd_valid", {31'b0, rd_valid}, 32'd0);
          chk("wdone_cycle", cyc, last_wr_cyc + 1);
        end else begin
          chk("rdone_rd_valid", {31'b0, rd_valid}, 32'd1);
          chk("rdone_cycle", cyc - cur_acc + 1, cur_len + 2);
        end
      end
      if (ram_write_en) last_wr_cyc = cyc;
    end
  end

  // Present a request, wait for acceptance, and record the expected effects.
  task automatic issue(input bit wr, input logic [9:0] a, input logic [3:0] l);
    int n = 0;
    req_write = wr; req_addr = a; req_len = l; req_valid = 1'b1;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail_now("issue_timeout", n);
    for (int i = 0; i <= int'(l); i++) begin
      logic [9:0] ad;
      ad = a + 10'(i);
      if (wr) begin
        exp_wr.push_back('{a: ad, d: wq[i]});
        ref_mem[ad] = wq[i];
      end else begin
        exp_ra.push_back(ad);
        exp_rd.push_back(ref_mem[ad]);
      end
    end
    if (wr) pm_wr = (pm_wr + int'(l) + 1 > 65535) ? 65535 : pm_wr + int'(l) + 1;
    else    pm_rd = (pm_rd + int'(l) + 1 > 65535) ? 65535 : pm_rd + int'(l) + 1;
    done_exp++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cur_acc = cyc; cur_len = int'(l); cur_wr = wr; cur_id++;
  endtask

  task automatic wait_idle(output int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 400);
    if (!req_ready) fail_now("idle_timeout", n);
    lat = cyc - cur_acc + 1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [3:0] l, input int gmin, input int gmax);
    int gaps = 0, lat, g;
    issue(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (i > 0) begin
        g = $urandom_range(gmax, gmin);
        wr_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        gaps += g;
      end
      wr_valid = 1'b1;
      wr_data  = wq.pop_front();
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    wait_idle(lat);
    chk("wr_latency", lat, int'(l) + 3 + gaps);
  endtask

  task automatic do_read(input logic [9:0] a, input logic [3:0] l,
                         input bit busy, input logic [9:0] ba, input logic [3:0] bl);
    int lat;
    issue(1'b0, a, l);
    if (busy) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = ba; req_len = bl;
    end
    wait_idle(lat);
    chk("rd_latency", lat, int'(l) + 3);
  endtask

  task automatic fill_wq(input int n);
    for (int i = 0; i < n; i++) wq.push_back(16'($urandom_range(0, 65535)));
  endtask

  initial begin
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ram_en", {30'b0, ram_read_en, ram_write_en}, 32'd0);
    chk("rst_ram_addr", {22'b0, ram_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int b = 0; b < 64; b++) begin
      fill_wq(16);
      do_write(10'(b * 16), 4'd15, 0, 0);
    end

    wq.push_back(16'hBEEF);
    do_write(10'h005, 4'd0, 0, 0);
    do_read(10'h005, 4'd0, 1'b0, '0, '0);

    wq.push_back(16'h1111); wq.push_back(16'h2222);
    wq.push_back(16'h3333); wq.push_back(16'h4444);
    do_write(10'h3FE, 4'd3, 0, 0);
    do_read(10'h3FE, 4'd3, 1'b0, '0, '0);

    fill_wq(3);
    do_write(10'h100, 4'd2, 3, 3);

    do_read(10'h050, 4'd15, 1'b1, 10'h200, 4'd5);
    do_read(10'h200, 4'd5, 1'b0, '0, '0);

    // Reset in cycle 3 of an 8-word read.
    issue(1'b0, 10'h010, 4'd7);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_ram_en", {30'b0, ram_read_en, ram_write_en}, 32'd0);
    chk("mid_rst_ram_addr", {22'b0, ram_addr}, 32'd0);
    exp_rd.delete();
    exp_ra.delete();
    done_exp--;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
      chk("post_rst_quiet", {30'b0, rd_valid, done}, 32'd0);
    end
    @(posedge clk);
    #1;

    for (int k = 0; k < 40; k++) begin
      logic [9:0] a;
      logic [3:0] l;
      a = 10'($urandom_range(0, 1023));
      l = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        fill_wq(int'(l) + 1);
        do_write(a, l, 0, 2);
      end else begin
        do_read(a, l, 1'b0, '0, '0);
      end
    end

`ifdef MEM_CTRL_PERF_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    pm_rd = 0; pm_wr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_wq(3);
    do_write(10'h020, 4'd2, 0, 0);
    do_read(10'h030, 4'd4, 1'b0, '0, '0);
    chk("perf_wr_small", {16'b0, perf_wr_cnt}, pm_wr);
    chk("perf_rd_small", {16'b0, perf_rd_cnt}, pm_rd);
    for (int k = 0; k < 4125; k++) do_read(10'($urandom_range(0, 1023)), 4'd15, 1'b0, '0, '0);
    chk("perf_rd_sat", {16'b0, perf_rd_cnt}, pm_rd);
    chk("perf_rd_sat_abs", {16'b0, perf_rd_cnt}, 32'h0000FFFF);
    chk("perf_wr_hold", {16'b0, perf_wr_cnt}, pm_wr);
`endif

    repeat (3) @(negedge clk);
    chk("done_count", done_seen, done_exp);
    chk("exp_wr_empty", exp_wr.size(), 0);
    chk("exp_rd_empty", exp_rd.size(), 0);
    chk("exp_ra_empty", exp_ra.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
